depatchifier: RTL and testbench
===============================

Name: depatchifier

Overview:
- Inverse of the patch stage: accepts pixels in patch-major order (patch 0 pos 0..PATCH_VECTOR_SIZE-1, then patch 1, ...) over a valid/ready stream.
- Stores one full frame in an internal buffer, then replays it in raster order (row 0 col 0..IMG_WIDTH-1, row 1, ...) over a second valid/ready stream.
- Sits after the transformer output/reconstruction path and feeds image-domain consumers or the frame writer.

Parameters:
- CHANNEL_SIZE, 8, bits per channel
- NUM_CHANNELS, 3, channels per pixel (RGB)
- PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, pixel word width
- IMG_WIDTH, 64, columns; must be a multiple of PATCH_SIZE
- IMG_HEIGHT, 64, rows; must be a multiple of PATCH_SIZE
- PATCH_SIZE, 16, patch edge; must be a power of 2
- PATCH_SIZE_LOG2, 4, log2(PATCH_SIZE)
- PATCHES_IN_ROW, IMG_WIDTH/PATCH_SIZE, derived
- TOTAL_NUM_PATCHES, (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE), derived
- PATCH_VECTOR_SIZE, PATCH_SIZE*PATCH_SIZE, derived

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- en  in  1  start a frame; sampled only in IDLE
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept an input pixel
- in_pixel  in  PIXEL_WIDTH  input pixel, patch-major order
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts output pixel
- out_pixel  out  PIXEL_WIDTH  output pixel, raster order
- out_row  out  $clog2(IMG_HEIGHT)  row of out_pixel
- out_col  out  $clog2(IMG_WIDTH)  column of out_pixel
- out_last  out  1  out_pixel is (IMG_HEIGHT-1, IMG_WIDTH-1)
- state  out  2  00 IDLE, 01 FILL, 10 DRAIN

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, all counters 0, in_ready=0, out_valid=0, out_last=0, out_row=0, out_col=0. Buffer contents are not cleared; out_pixel is don't-care while out_valid=0.
- IDLE: in_ready=0, out_valid=0. en=1 -> FILL on the next edge, with input counters (patch_cnt, pos_cnt) cleared.
- FILL: in_ready=1 (combinational from state). On each in_valid&&in_ready:
  - Compute pr=pos_cnt>>L, pc=pos_cnt&(PATCH_SIZE-1), row=(patch_cnt/PATCHES_IN_ROW)*PATCH_SIZE+pr, col=(patch_cnt%PATCHES_IN_ROW)*PATCH_SIZE+pc, where L=PATCH_SIZE_LOG2.
  - Write buf[row][col] <= in_pixel.
  - Increment pos_cnt; when pos_cnt wraps at PATCH_VECTOR_SIZE-1, set it to 0 and increment patch_cnt.
- On the accept with patch_cnt=TOTAL_NUM_PATCHES-1 and pos_cnt=PATCH_VECTOR_SIZE-1: state -> DRAIN on the same edge. in_ready is 0 from the next cycle. No cycle of in_ready=1 follows the final accept.
- DRAIN: out_valid=1.
  - out_pixel=buf[out_row][out_col], combinational read of the flop array.
  - out_last=(out_row==IMG_HEIGHT-1 && out_col==IMG_WIDTH-1).
  - On out_valid&&out_ready: out_col increments; on wrap it returns to 0 and out_row increments.
  - Accept with out_last=1 -> IDLE, out_row=out_col=0.
- Latency: first out_valid is the cycle after the final input accept; one frame is IMG_WIDTH*IMG_HEIGHT accepts each way.
- Backpressure: while out_valid&&!out_ready, out_pixel/out_row/out_col/out_last are held stable.
- in_valid outside FILL is ignored and nothing is written. en outside IDLE is ignored. en=1 in IDLE on the cycle after DRAIN completes starts a new frame, so the minimum gap between frames is 1 IDLE cycle.
- Reset mid-FILL or mid-DRAIN aborts the frame. The next frame after reset is fully correct; a partial buffer must not leak into it because every location is rewritten in FILL.
- Counters are sized exactly: patch_cnt $clog2(TOTAL_NUM_PATCHES), pos_cnt $clog2(PATCH_VECTOR_SIZE). No int-width counters.
- Divide and modulo by PATCHES_IN_ROW must be constant-foldable, or replaced by a separate patch_col/patch_row counter pair (preferred).

Decomposition:
- Shared package (vit_img_pkg):
  - State localparams IDLE/FILL/DRAIN (2'b00/2'b01/2'b10), shared with the patch stage.
  - Geometry parameters and derived constants.
  - Function patch_to_raster(patch, pos) -> {row, col}, used here and by verification models.
- No sub-module needed; the buffer is an inline register array. An optional patch_addr_gen sub-module holds the patch_row/patch_col/pos counter chain.

Test Plan (IMG 8x8, PATCH_SIZE 4, L=2, so 4 patches of 16 pixels):
- Ramp: send in_pixel=k for k=0..63 in patch order, out_ready=1. Expect out_pixel at (0,0)=0, (0,4)=16, (1,0)=4, (4,0)=32, (7,7)=63 with out_last=1, and state back to 00 after that accept.
- Round trip: patch stage output of a random 8x8 image fed in patch-major order -> raster output bit-exact equal to the original image, 64 beats.
- Output backpressure: out_ready toggling 1,0,0,1 pattern -> output held stable while out_ready=0; exactly 64 accepts, no duplicate or skipped (row,col).
- Input bubbles/protocol: in_valid=1 while IDLE -> in_ready=0 and no write. Random in_valid gaps in FILL -> ramp result unchanged. in_ready=0 on the cycle after the 64th accept.
- Reset mid-FILL after 20 accepts (reset=0 for 1 cycle, asynchronous) -> state=00, in_ready=0, out_valid=0 immediately. A following ramp frame matches the ramp expectations.
- en ignored in FILL/DRAIN. en held 1 continuously -> back-to-back frames with exactly one IDLE cycle between the last output accept and in_ready=1.

Source files
------------

// File: rtl/vit_img_pkg.sv
// Shared image/patch geometry, stage state encoding and the patch-to-raster
// mapping used by the patchifier/depatchifier pair and their models.
package vit_img_pkg;

  localparam int unsigned DEF_CHANNEL_SIZE    = 8;
  localparam int unsigned DEF_NUM_CHANNELS    = 3;
  localparam int unsigned DEF_PIXEL_WIDTH     = DEF_CHANNEL_SIZE * DEF_NUM_CHANNELS;
  localparam int unsigned DEF_IMG_WIDTH       = 64;
  localparam int unsigned DEF_IMG_HEIGHT      = 64;
  localparam int unsigned DEF_PATCH_SIZE      = 16;
  localparam int unsigned DEF_PATCH_SIZE_LOG2 = 4;
  localparam int unsigned DEF_PATCHES_IN_ROW  = DEF_IMG_WIDTH / DEF_PATCH_SIZE;
  localparam int unsigned DEF_PATCHES_IN_COL  = DEF_IMG_HEIGHT / DEF_PATCH_SIZE;
  localparam int unsigned DEF_TOTAL_NUM_PATCHES = DEF_PATCHES_IN_ROW * DEF_PATCHES_IN_COL;
  localparam int unsigned DEF_PATCH_VECTOR_SIZE = DEF_PATCH_SIZE * DEF_PATCH_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    DRAIN = 2'b10
  } stage_state_e;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
  } raster_pos_t;

  // Keeps counter widths at least one bit when a dimension collapses to 1.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic raster_pos_t patch_to_raster(
    input int unsigned patch,
    input int unsigned pos,
    input int unsigned patches_in_row,
    input int unsigned patch_size_log2
  );
    int unsigned ps;
    raster_pos_t rp;
    ps     = 32'd1 << patch_size_log2;
    rp.row = 16'((patch / patches_in_row) * ps + (pos >> patch_size_log2));
    rp.col = 16'((patch % patches_in_row) * ps + (pos & (ps - 1)));
    return rp;
  endfunction

endpackage

// File: rtl/depatchifier_addr_gen.sv
// Write-address chain for patch-major input: pos within patch, then patch
// column, then patch row; yields the raster (row, col) of the current beat.
module depatchifier_addr_gen
  import vit_img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH       = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT      = DEF_IMG_HEIGHT,
  parameter int unsigned PATCH_SIZE      = DEF_PATCH_SIZE,
  parameter int unsigned PATCH_SIZE_LOG2 = DEF_PATCH_SIZE_LOG2,
  localparam int unsigned ROW_W = safe_clog2(IMG_HEIGHT),
  localparam int unsigned COL_W = safe_clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             step_i,
  output logic [ROW_W-1:0] wr_row_o,
  output logic [COL_W-1:0] wr_col_o,
  output logic             last_o
);

  localparam int unsigned PATCHES_IN_ROW = IMG_WIDTH / PATCH_SIZE;
  localparam int unsigned PATCHES_IN_COL = IMG_HEIGHT / PATCH_SIZE;
  localparam int unsigned PC_W  = safe_clog2(PATCHES_IN_ROW);
  localparam int unsigned PR_W  = safe_clog2(PATCHES_IN_COL);
  localparam int unsigned POS_W = 2 * PATCH_SIZE_LOG2;

  logic [POS_W-1:0] pos_q, pos_d;
  logic [PC_W-1:0]  patch_col_q, patch_col_d;
  logic [PR_W-1:0]  patch_row_q, patch_row_d;
  logic             pos_wrap, patch_col_wrap, patch_row_wrap;

  // PATCH_VECTOR_SIZE is a power of two, so the last position is all ones.
  assign pos_wrap       = (pos_q == '1);
  assign patch_col_wrap = (patch_col_q == PC_W'(PATCHES_IN_ROW - 1));
  assign patch_row_wrap = (patch_row_q == PR_W'(PATCHES_IN_COL - 1));
  assign last_o         = pos_wrap && patch_col_wrap && patch_row_wrap;

  assign wr_row_o = (ROW_W'(patch_row_q) << PATCH_SIZE_LOG2)
                  + ROW_W'(pos_q[POS_W-1:PATCH_SIZE_LOG2]);
  assign wr_col_o = (COL_W'(patch_col_q) << PATCH_SIZE_LOG2)
                  + COL_W'(pos_q[PATCH_SIZE_LOG2-1:0]);

  always_comb begin
    pos_d       = pos_q;
    patch_col_d = patch_col_q;
    patch_row_d = patch_row_q;
    if (clear_i) begin
      pos_d       = '0;
      patch_col_d = '0;
      patch_row_d = '0;
    end else if (step_i) begin
      pos_d = pos_q + 1'b1;
      if (pos_wrap) begin
        if (patch_col_wrap) begin
          patch_col_d = '0;
          patch_row_d = patch_row_wrap ? '0 : patch_row_q + 1'b1;
        end else begin
          patch_col_d = patch_col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q       <= '0;
      patch_col_q <= '0;
      patch_row_q <= '0;
    end else begin
      pos_q       <= pos_d;
      patch_col_q <= patch_col_d;
      patch_row_q <= patch_row_d;
    end
  end

endmodule

// File: rtl/depatchifier.sv
// Collects one frame of patch-major pixels into a register array, then
// replays it in raster order with row/column tags and an end-of-frame flag.
module depatchifier
  import vit_img_pkg::*;
#(
  parameter int unsigned CHANNEL_SIZE    = DEF_CHANNEL_SIZE,
  parameter int unsigned NUM_CHANNELS    = DEF_NUM_CHANNELS,
  parameter int unsigned PIXEL_WIDTH     = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int unsigned IMG_WIDTH       = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT      = DEF_IMG_HEIGHT,
  parameter int unsigned PATCH_SIZE      = DEF_PATCH_SIZE,
  parameter int unsigned PATCH_SIZE_LOG2 = DEF_PATCH_SIZE_LOG2,
  localparam int unsigned ROW_W = safe_clog2(IMG_HEIGHT),
  localparam int unsigned COL_W = safe_clog2(IMG_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic [ROW_W-1:0]       out_row,
  output logic [COL_W-1:0]       out_col,
  output logic                   out_last,
  output logic [1:0]             state
);

  // Handshakes: a beat transfers on a rising edge where valid && ready.
  // in_ready depends only on state; out_valid never depends on out_ready,
  // and all output fields hold steady while out_valid && !out_ready.

  stage_state_e           state_q, state_d;
  logic [ROW_W-1:0]       out_row_q, out_row_d;
  logic [COL_W-1:0]       out_col_q, out_col_d;
  logic [PIXEL_WIDTH-1:0] frame_q [IMG_HEIGHT][IMG_WIDTH];

  logic             in_fire, out_fire, addr_clear, fill_done;
  logic             at_row_end, at_last;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign addr_clear = (state_q == IDLE) && en;

  assign at_row_end = (out_col_q == COL_W'(IMG_WIDTH - 1));
  assign at_last    = at_row_end && (out_row_q == ROW_W'(IMG_HEIGHT - 1));
  assign out_last   = out_valid && at_last;

  assign out_pixel = frame_q[out_row_q][out_col_q];
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign state     = state_q;

  depatchifier_addr_gen #(
    .IMG_WIDTH       (IMG_WIDTH),
    .IMG_HEIGHT      (IMG_HEIGHT),
    .PATCH_SIZE      (PATCH_SIZE),
    .PATCH_SIZE_LOG2 (PATCH_SIZE_LOG2)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (addr_clear),
    .step_i   (in_fire),
    .wr_row_o (wr_row),
    .wr_col_o (wr_col),
    .last_o   (fill_done)
  );

  always_comb begin
    state_d   = state_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = FILL;
      end
      FILL: begin
        if (in_fire && fill_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_fire) begin
          if (at_last) begin
            state_d   = IDLE;
            out_row_d = '0;
            out_col_d = '0;
          end else if (at_row_end) begin
            out_col_d = '0;
            out_row_d = out_row_q + 1'b1;
          end else begin
            out_col_d = out_col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      state_q   <= state_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  end

  // Frame storage is never cleared: FILL rewrites every location.
  always_ff @(posedge clk) begin
    if (in_fire) frame_q[wr_row][wr_col] <= in_pixel;
  end

endmodule

// File: tb/tb_depatchifier.sv
// Bench for depatchifier on an 8x8 image with 4x4 patches: random frames,
// input gaps, output backpressure, mid-frame reset and back-to-back frames.
module tb_depatchifier;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int PS   = 4;
  localparam int PL   = 2;
  localparam int PW   = 24;
  localparam int RW   = 3;
  localparam int CW   = 3;
  localparam int NPIX = W * H;
  localparam int EW   = 1 + RW + CW + PW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pixel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pixel;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;
  logic [1:0]    state;

  depatchifier #(
    .CHANNEL_SIZE    (8),
    .NUM_CHANNELS    (3),
    .IMG_WIDTH       (W),
    .IMG_HEIGHT      (H),
    .PATCH_SIZE      (PS),
    .PATCH_SIZE_LOG2 (PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .state     (state)
  );

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] img [NPIX];
  logic [PW-1:0] got [NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard: every accepted output beat is compared with the raster model
  logic          stall_held = 1'b0;
  logic [EW-1:0] held_word;
  logic [EW-1:0] exp_word;

  always @(negedge clk) begin
    if (!reset) begin
      stall_held = 1'b0;
    end else begin
      if (stall_held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_word", 32'({out_last, out_row, out_col, out_pixel}), 32'(held_word));
      end
      stall_held = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got row %0d col %0d, want no output", out_row, out_col);
        end else begin
          exp_word = exp_q.pop_front();
          check("out_word", 32'({out_last, out_row, out_col, out_pixel}), 32'(exp_word));
          got[int'(out_row) * W + int'(out_col)] = out_pixel;
        end
      end else if (out_valid) begin
        stall_held = 1'b1;
        held_word  = {out_last, out_row, out_col, out_pixel};
      end
    end
  end

  // stimulus helpers
  task automatic make_ramp();
    for (int p = 0; p < NPIX / (PS * PS); p++)
      for (int q = 0; q < PS * PS; q++)
        img[((p / (W / PS)) * PS + q / PS) * W + (p % (W / PS)) * PS + q % PS] = PW'(p * PS * PS + q);
  endtask

  task automatic make_random();
    for (int i = 0; i < NPIX; i++) img[i] = PW'($urandom);
  endtask

  task automatic clear_got();
    for (int i = 0; i < NPIX; i++) got[i] = '1;
  endtask

  task automatic start_frame(input bit hold);
    en = 1'b1;
    @(negedge clk);
    check("start_idle", 32'(state), 32'd0);
    @(posedge clk); #1;
    check("start_fill", 32'(state), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
    if (!hold) en = 1'b0;
  endtask

  // Sends the first n_beats pixels of img in patch-major order.
  task automatic send_frame(input int gap_pct, input int n_beats);
    int n;
    n = 0;
    for (int p = 0; p < NPIX / (PS * PS) && n < n_beats; p++) begin
      for (int q = 0; q < PS * PS && n < n_beats; q++) begin
        int r, c;
        r = (p / (W / PS)) * PS + q / PS;
        c = (p % (W / PS)) * PS + q % PS;
        while ($urandom_range(99) < gap_pct) begin
          in_valid = 1'b0;
          in_pixel = PW'($urandom);
          @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_pixel = img[r * W + c];
        @(negedge clk);
        check("fill_in_ready", 32'(in_ready), 32'd1);
        check("fill_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        n++;
      end
    end
    in_valid = 1'b0;
    if (n_beats == NPIX) begin
      check("post_fill_in_ready", 32'(in_ready), 32'd0);
      check("post_fill_out_valid", 32'(out_valid), 32'd1);
      check("post_fill_state", 32'(state), 32'd2);
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          exp_q.push_back({(r == H - 1 && c == W - 1), RW'(r), CW'(c), img[r * W + c]});
    end
  endtask

  // bp_mode 0: always ready, 1: 1,0,0,1 pattern, 2: random
  task automatic drain(input int bp_mode, input bit junk);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 1000) begin
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(1));
      endcase
      if (junk) begin
        in_valid = 1'($urandom_range(1));
        in_pixel = PW'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
      exp_q.delete();
    end
    check("post_drain_state", 32'(state), 32'd0);
    check("post_drain_out_valid", 32'(out_valid), 32'd0);
    check("post_drain_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic pin_ramp();
    check("ramp_0_0", 32'(got[0 * W + 0]), 32'd0);
    check("ramp_0_4", 32'(got[0 * W + 4]), 32'd16);
    check("ramp_1_0", 32'(got[1 * W + 0]), 32'd4);
    check("ramp_4_0", 32'(got[4 * W + 0]), 32'd32);
    check("ramp_7_7", 32'(got[7 * W + 7]), 32'd63);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_row", 32'(out_row), 32'd0);
    check("rst_out_col", 32'(out_col), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // input offered while idle is refused
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pixel = PW'($urandom);
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_state", 32'(state), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // ramp frame, no stalls
    make_ramp();
    clear_got();
    start_frame(1'b0);
    send_frame(0, NPIX);
    drain(0, 1'b0);
    pin_ramp();

    // random frame with gaps, 1,0,0,1 backpressure, en held high throughout
    make_random();
    start_frame(1'b1);
    send_frame(30, NPIX);
    drain(1, 1'b1);
    @(posedge clk); #1;
    check("b2b_state", 32'(state), 32'd1);
    check("b2b_in_ready", 32'(in_ready), 32'd1);

    // back-to-back ramp with gaps; en released during the frame
    make_ramp();
    clear_got();
    send_frame(40, NPIX);
    en = 1'b0;
    drain(2, 1'b1);
    pin_ramp();
    @(posedge clk); #1;
    check("stay_idle", 32'(state), 32'd0);

    // abort after 20 accepts with an asynchronous reset pulse
    make_random();
    start_frame(1'b0);
    send_frame(10, 20);
    #2 reset = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", 32'(state), 32'd0);

    make_ramp();
    clear_got();
    start_frame(1'b0);
    send_frame(0, NPIX);
    drain(0, 1'b0);
    pin_ramp();

    // random frames, random gaps and backpressure
    for (int f = 0; f < 4; f++) begin
      make_random();
      start_frame(1'b0);
      send_frame($urandom_range(50), NPIX);
      drain(2, 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
